// File: rtl/exibidor_contador_7seg_pkg.sv
// Shared constants for the two-digit 7-segment count display.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package exibidor_contador_7seg_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   localparam logic [1:0] AN_UNITS  = 2'b10;
   localparam logic [1:0] AN_TENS   = 2'b01;
   localparam logic [1:0] AN_NONE   = 2'b11;

endpackage

// File: rtl/exibidor_contador_7seg_decod.sv
// Combinational BCD to active-low 7-segment pattern; non-BCD codes show a dash.
module decodificador_7seg
   import exibidor_contador_7seg_pkg::*;
(
   input  logic [3:0] i_bcd,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_DASH;
      case (i_bcd)
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         4'd9:    o_seg = SEG_9;
         default: o_seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/exibidor_contador_7seg.sv
// Captures the upstream count, splits it into tens/units and drives a
// two-digit multiplexed common-anode display with wrap and range flags.
module exibidor_contador_7seg
   import exibidor_contador_7seg_pkg::*;
#(
   parameter int REFRESH_DIV = 50000,
   parameter int MAX_COUNT   = 13
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] count_in,
   input  logic       hold,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic       dp,
   output logic       wrap_pulse,
   output logic       err
);

   localparam int             RW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [RW-1:0]  REF_LAST = RW'(REFRESH_DIV - 1);
   localparam logic [3:0]     MAX_C    = 4'(MAX_COUNT);

   logic [3:0]    r_cap, r_prev;
   logic [RW-1:0] r_refresh_cnt;
   logic          r_sel;
   logic [6:0]    r_seg;
   logic [1:0]    r_an;
   logic          r_dp, r_wrap, r_err;

   logic          w_over, w_tens;
   logic [3:0]    w_units, w_digit;
   logic [6:0]    w_dec, w_seg_nxt;
   logic [1:0]    w_an_nxt;
   logic          w_dp_nxt;

   assign w_over  = (r_cap > MAX_C);
   assign w_tens  = (r_cap >= 4'd10);
   assign w_units = w_tens ? (r_cap - 4'd10) : r_cap;
   assign w_digit = r_sel ? {3'b000, w_tens} : w_units;

   decodificador_7seg u_dec (
      .i_bcd (w_digit),
      .o_seg (w_dec)
   );

   // Blank only the segments of a leading zero; the anode stays driven so the
   // duty cycle per digit is constant. Out-of-range overrides both digits.
   always_comb begin
      w_seg_nxt = w_dec;
      w_an_nxt  = AN_UNITS;
      w_dp_nxt  = ~hold;
      if (r_sel) begin
         w_an_nxt = AN_TENS;
         w_dp_nxt = 1'b1;
         if (!w_tens) w_seg_nxt = SEG_BLANK;
      end
      if (w_over) w_seg_nxt = SEG_DASH;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cap  <= '0;
         r_prev <= '0;
         r_wrap <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         if (!hold) r_cap <= count_in;
         r_prev <= r_cap;
         r_wrap <= (r_prev == MAX_C) && (r_cap == 4'd0);
         r_err  <= w_over;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_refresh_cnt <= '0;
         r_sel         <= 1'b0;
      end else if (r_refresh_cnt == REF_LAST) begin
         r_refresh_cnt <= '0;
         r_sel         <= ~r_sel;
      end else begin
         r_refresh_cnt <= r_refresh_cnt + 1'b1;
      end
   end

   // an and seg share one register stage so digits never ghost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg <= SEG_BLANK;
         r_an  <= AN_NONE;
         r_dp  <= 1'b1;
      end else begin
         r_seg <= w_seg_nxt;
         r_an  <= w_an_nxt;
         r_dp  <= w_dp_nxt;
      end
   end

   assign seg        = r_seg;
   assign an         = r_an;
   assign dp         = r_dp;
   assign wrap_pulse = r_wrap;
   assign err        = r_err;

endmodule

// File: tb/tb_exibidor_contador_7seg.sv
// Directed scoreboard bench: stimulus queues per-edge expectations, a monitor
// pops and compares them on the falling edge (or right after async reset).
module tb_exibidor_contador_7seg;

   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000, S7 = 7'b1111000;
   localparam logic [6:0] SB = 7'b1111111, SD = 7'b0111111;
   localparam logic [1:0] AU = 2'b10, AT = 2'b01, AX = 2'b11;

   typedef struct {
      int         k;
      logic [6:0] seg;
      logic [1:0] an;
      logic       dp, wr, er;
   } exp_t;

   logic       clk, rst_n, hold, dp, wrap_pulse, err;
   logic [3:0] count_in;
   logic [6:0] seg;
   logic [1:0] an;

   exp_t q[$];
   int   edge_no;
   int   k;
   int   n_vec, n_mis;
   event rst_evt;

   exibidor_contador_7seg #(.REFRESH_DIV(4), .MAX_COUNT(13)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .count_in   (count_in),
      .hold       (hold),
      .seg        (seg),
      .an         (an),
      .dp         (dp),
      .wrap_pulse (wrap_pulse),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n)
      if (!rst_n) edge_no <= 0;
      else        edge_no <= edge_no + 1;

   // Monitor: an expectation tagged k is due once edge k has happened.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk or rst_evt);
         while (q.size() > 0 && q[0].k <= edge_no) begin
            e = q.pop_front();
            n_vec++;
            if (e.k < edge_no) begin
               n_mis++;
               $display("FAIL stale edge%0d: expectation not checked in time (now edge%0d)", e.k, edge_no);
            end else if ({seg, an, dp, wrap_pulse, err} !== {e.seg, e.an, e.dp, e.wr, e.er}) begin
               n_mis++;
               $display("FAIL edge%0d: got seg=%b an=%b dp=%b wrap=%b err=%b, want seg=%b an=%b dp=%b wrap=%b err=%b",
                        e.k, seg, an, dp, wrap_pulse, err, e.seg, e.an, e.dp, e.wr, e.er);
            end
         end
      end
   end

   task automatic tn(input int n, input logic [3:0] cin, input logic hld,
                     input logic [6:0] s, input logic [1:0] a,
                     input logic d, input logic w, input logic e);
      for (int i = 0; i < n; i++) begin
         q.push_back(exp_t'{k: k + 1, seg: s, an: a, dp: d, wr: w, er: e});
         k++;
         count_in = cin;
         hold     = hld;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      n_vec = 0; n_mis = 0; k = 0;
      rst_n = 1'b0; count_in = 4'd0; hold = 1'b0;
      q.push_back(exp_t'{k: 0, seg: SB, an: AX, dp: 1'b1, wr: 1'b0, er: 1'b0});
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;

      // zero: units "0", tens blanked
      tn(4, 4'd0, 0, S0, AU, 1, 0, 0);
      tn(4, 4'd0, 0, SB, AT, 1, 0, 0);
      // 12: two-cycle latency, 4-cycle phases
      tn(1, 4'd12, 0, S0, AU, 1, 0, 0);
      tn(3, 4'd12, 0, S2, AU, 1, 0, 0);
      tn(4, 4'd12, 0, S1, AT, 1, 0, 0);
      tn(4, 4'd12, 0, S2, AU, 1, 0, 0);
      tn(4, 4'd12, 0, S1, AT, 1, 0, 0);
      // 12,13,0,1: single wrap pulse on the edge after cap hits 0
      tn(1, 4'd12, 0, S2, AU, 1, 0, 0);
      tn(1, 4'd13, 0, S2, AU, 1, 0, 0);
      tn(1, 4'd0,  0, S3, AU, 1, 0, 0);
      tn(1, 4'd1,  0, S0, AU, 1, 1, 0);
      tn(4, 4'd1,  0, SB, AT, 1, 0, 0);
      // hold freezes 7, dp lit on units; release to 0 gives no pulse
      tn(1, 4'd7,  0, S1, AU, 1, 0, 0);
      tn(1, 4'd7,  1, S7, AU, 0, 0, 0);
      tn(1, 4'd13, 1, S7, AU, 0, 0, 0);
      tn(1, 4'd0,  1, S7, AU, 0, 0, 0);
      tn(4, 4'd0,  1, SB, AT, 1, 0, 0);
      tn(3, 4'd0,  1, S7, AU, 0, 0, 0);
      tn(1, 4'd0,  0, S7, AU, 1, 0, 0);
      tn(4, 4'd0,  0, SB, AT, 1, 0, 0);
      tn(1, 4'd0,  0, S0, AU, 1, 0, 0);
      // out of range: dash on both digits, err tracks cap
      tn(1, 4'd14, 0, S0, AU, 1, 0, 0);
      tn(2, 4'd14, 0, SD, AU, 1, 0, 1);
      tn(4, 4'd14, 0, SD, AT, 1, 0, 1);
      tn(1, 4'd3,  0, SD, AU, 1, 0, 1);
      tn(1, 4'd12, 0, S3, AU, 1, 0, 0);
      tn(2, 4'd12, 0, S2, AU, 1, 0, 0);
      tn(2, 4'd12, 0, S1, AT, 1, 0, 0);

      // async reset in the middle of a tens phase, between edges
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      q.push_back(exp_t'{k: 0, seg: SB, an: AX, dp: 1'b1, wr: 1'b0, er: 1'b0});
      -> rst_evt;
      @(posedge clk); @(posedge clk); #1;
      k = 0;
      rst_n = 1'b1;
      tn(1, 4'd12, 0, S0, AU, 1, 0, 0);
      tn(3, 4'd12, 0, S2, AU, 1, 0, 0);
      tn(1, 4'd12, 0, S1, AT, 1, 0, 0);

      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      #1;
      if (q.size() > 0) begin
         n_mis++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
